// File: rtl/fifo_wr_if.sv
// fifo_wr_if: producer, RAM-write and cross-domain pointer signals of the FIFO write side
interface fifo_wr_if #(parameter int WIDTH = 16, ADDR = 4);
  logic             wr_req;
  logic [WIDTH-1:0] wr_din;
  logic [ADDR:0]    rd_ptr_gray;
  logic             ovf_clr;
  logic             wr_en;
  logic [ADDR-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [ADDR:0]    wr_ptr_gray;
  logic             full;
  logic             almost_full;
  logic [ADDR:0]    wr_level;
  logic             overflow;
  modport master (
    output wr_req, wr_din, rd_ptr_gray, ovf_clr,
    input  wr_en, wr_addr, wr_data, wr_ptr_gray, full, almost_full, wr_level, overflow
  );
  modport slave (
    input  wr_req, wr_din, rd_ptr_gray, ovf_clr,
    output wr_en, wr_addr, wr_data, wr_ptr_gray, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-side controller of an async FIFO with Gray pointer handoff and sticky overflow
module fifo_wr_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int ADDR = 4,
  parameter int AF_LEVEL = 14
) (
  input logic      wrclk,
  input logic      rd_rst_n,
  fifo_wr_if.slave bus
);
  logic [ADDR:0] wbin, wgray, rq1, rq2, rbin, wbin_next, wgray_next, level_next, wr_level;
  logic full, almost_full, overflow, wr_en;
  if (DEPTH != (1 << ADDR)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR");
  end
  assign wr_en = bus.wr_req & ~full & rd_rst_n;
  // rbin[i] is the parity of all Gray bits at or above i
  for (genvar i = 0; i <= ADDR; i++) begin : g_rbin
    assign rbin[i] = ^(rq2 >> i);
  end
  always_comb begin
    wbin_next  = wbin + (ADDR+1)'(wr_en);
    wgray_next = wbin_next ^ (wbin_next >> 1);
    level_next = wbin_next - rbin;
  end
  always_ff @(posedge wrclk or negedge rd_rst_n)
    if (!rd_rst_n) begin
      wbin        <= '0;
      wgray       <= '0;
      rq1         <= '0;
      rq2         <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wgray       <= wgray_next;
      rq1         <= bus.rd_ptr_gray;
      rq2         <= rq1;
      wr_level    <= level_next;
      full        <= wgray_next == {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]};
      almost_full <= level_next >= (ADDR+1)'(AF_LEVEL);
      overflow    <= (bus.wr_req & full) | (overflow & ~bus.ovf_clr);
    end
  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wbin[ADDR-1:0];
  assign bus.wr_data     = WIDTH'(bus.wr_din);
  assign bus.wr_ptr_gray = wgray;
  assign bus.full        = full;
  assign bus.almost_full = almost_full;
  assign bus.wr_level    = wr_level;
  assign bus.overflow    = overflow;
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data bus width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the storage depth in words and SHALL equal 2^ADDR.
REQ-003 Parameter ADDR, default 4, SHALL set the RAM address width in bits.
REQ-004 Parameter AF_LEVEL, default 14, SHALL set the almost-full threshold in words, range 1..DEPTH.
REQ-005 wrclk  input  1: write-domain clock, all state on posedge.
REQ-006 rd_rst_n  input  1: reset, asynchronous, active-low.
REQ-007 wr_req  input  1: push request from the producer.
REQ-008 wr_din  input  WIDTH: push data.
REQ-009 rd_ptr_gray  input  ADDR+1: read pointer from the read clock domain, Gray-coded, asynchronous to wrclk.
REQ-010 ovf_clr  input  1: clears the sticky overflow flag.
REQ-011 wr_en  output  1: RAM write strobe.
REQ-012 wr_addr  output  ADDR: RAM write address.
REQ-013 wr_data  output  WIDTH: RAM write data.
REQ-014 wr_ptr_gray  output  ADDR+1: registered Gray write pointer for the read domain.
REQ-015 full  output  1: registered FIFO-full flag.
REQ-016 almost_full  output  1: registered level >= AF_LEVEL.
REQ-017 wr_level  output  ADDR+1: registered fill-level estimate, 0..DEPTH.
REQ-018 overflow  output  1: sticky flag, set when a push is rejected.

Function
REQ-019 State SHALL be: binary pointer wbin[ADDR:0], Gray pointer wgray[ADDR:0], 2-flop synchronizer rq1/rq2[ADDR:0] for rd_ptr_gray, and registers full, almost_full, wr_level, overflow.
REQ-020 Accept SHALL be combinational: wr_en = wr_req & ~full.
REQ-021 wr_addr SHALL equal wbin[ADDR-1:0], and wr_data SHALL equal wr_din, combinationally.
REQ-022 On each edge: wbin_next = wbin + wr_en (mod 2^(ADDR+1)); wgray_next = wbin_next ^ (wbin_next >> 1); wbin <= wbin_next; wgray <= wgray_next.
REQ-023 wr_ptr_gray SHALL be wgray, changing at most one bit per edge.
REQ-024 Synchronizer: rq1 <= rd_ptr_gray; rq2 <= rq1; no other logic SHALL sample rd_ptr_gray.
REQ-025 full SHALL register (wgray_next == {~rq2[ADDR:ADDR-1], rq2[ADDR-2:0]}).
REQ-026 rbin SHALL be the Gray-to-binary conversion of rq2; wr_level SHALL register (wbin_next - rbin) mod 2^(ADDR+1).
REQ-027 almost_full SHALL register (wbin_next - rbin) >= AF_LEVEL.
REQ-028 A rejected push (wr_req & full) SHALL set overflow on the next edge; ovf_clr SHALL clear it; when both occur in the same cycle, set SHALL win.
REQ-029 Write latency: the push SHALL be written to the RAM on the same wrclk edge, and full, wr_level and wr_ptr_gray SHALL reflect it after that edge.
REQ-030 Read release latency: a change on rd_ptr_gray SHALL affect full, almost_full and wr_level after the 3rd wrclk edge (rq1, rq2, then flag register).
REQ-031 Wrap: wbin SHALL wrap from 2^(ADDR+1)-1 to 0, and wr_addr SHALL wrap from DEPTH-1 to 0, with no gap.
REQ-032 full SHALL never deassert except through an rq2 change; pessimistic (late) deassertion is correct behaviour.

Reset
REQ-033 While rd_rst_n=0: wbin, wgray, rq1, rq2, wr_level = 0; full, almost_full, overflow = 0; wr_en = 0 regardless of wr_req.
REQ-034 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge; after release, the first push SHALL write address 0.

Verification (DEPTH=16, ADDR=4, AF_LEVEL=14)
REQ-035 Reset, then wr_req=0 for 4 edges -> all outputs 0 and wr_ptr_gray=5'b00000.
REQ-036 rd_ptr_gray=0, 16 consecutive pushes -> wr_addr 0..15 then 0; almost_full=1 after the 14th edge; full=1 after the 16th edge; wr_level=16; wr_ptr_gray=5'b11000.
REQ-037 From full, a 17th push -> wr_en=0, no pointer change, overflow=1 after the edge; ovf_clr=1 for 1 cycle -> overflow=0; ovf_clr and a rejected push in the same cycle -> overflow stays 1.
REQ-038 From full, set rd_ptr_gray=5'b00001 -> full=0 and wr_level=15 after the 3rd edge (not before); the next push writes addr 0, and full=1 again.
REQ-039 Run 40 pushes, with rd_ptr_gray tracking 2 words behind -> pointer wraps past 31 to 0; full never asserts; each wr_ptr_gray step changes exactly 1 bit.
REQ-040 Assert rd_rst_n=0 between clock edges after 5 pushes -> outputs clear asynchronously; after release, the first push writes wr_addr=0.
